// File: rtl/hs_rx_fifo.sv
// hs_rx_fifo: receive side of the 4-phase byte handshake, feeding a small FIFO.
// Captures one byte per rdy_i assertion, answers with a registered ack_o
// pulse of ACK_HOLD cycles, withholds ack while the FIFO is full, and
// offers a registered read port (rd_data/rd_valid) to downstream logic.
// Optional feature macro: HS_RX_BYTECNT_EN adds a 16-bit wrapping count
// of FIFO writes on output rx_bytes.
module hs_rx_fifo #(
  parameter int DEPTH    = 4,
  parameter int ACK_HOLD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy_i,
  input  logic [7:0]               data_i,
  output logic                     ack_o,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
`ifdef HS_RX_BYTECNT_EN
  ,
  output logic [15:0]              rx_bytes
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'b00,
    RX_ACK      = 2'b01,
    RX_WAIT_LOW = 2'b10
  } rx_state_t;

  rx_state_t         state_r;
  rx_state_t         next_state_s;
  logic [HW-1:0]     hold_r;
  logic [HW-1:0]     hold_nxt_s;
  logic              ack_r;

  logic [7:0]        mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_nxt_s;
  logic              empty_r;
  logic              full_r;
  logic [7:0]        rd_data_r;
  logic              rd_valid_r;

  logic              wr_fire_s;
  logic              rd_fire_s;

  // Pop is only honoured when the registered empty flag says there is data.
  always_comb begin
    rd_fire_s = rd_en & ~empty_r;
  end

  // Handshake FSM next-state: single capture per rdy_i assertion, ack hold timing.
  always_comb begin
    next_state_s = state_r;
    hold_nxt_s   = hold_r;
    wr_fire_s    = 1'b0;
    case (state_r)
      RX_IDLE: begin
        // Pre-edge full flag decides: a same-cycle pop does not free a slot.
        if (rdy_i && !full_r) begin
          wr_fire_s    = 1'b1;
          next_state_s = RX_ACK;
          hold_nxt_s   = HW'(ACK_HOLD - 1);
        end else begin
          next_state_s = RX_IDLE;
        end
      end
      RX_ACK: begin
        if (hold_r == {HW{1'b0}}) begin
          next_state_s = RX_WAIT_LOW;
        end else begin
          hold_nxt_s   = hold_r - HW'(1);
        end
      end
      RX_WAIT_LOW: begin
        if (!rdy_i) begin
          next_state_s = RX_IDLE;
        end else begin
          next_state_s = RX_WAIT_LOW;
        end
      end
      default: begin
        next_state_s = RX_IDLE;
        hold_nxt_s   = {HW{1'b0}};
      end
    endcase
  end

  // Handshake FSM state, hold counter and registered ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RX_IDLE;
      hold_r  <= {HW{1'b0}};
      ack_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      hold_r  <= hold_nxt_s;
      ack_r   <= (next_state_s == RX_ACK);
    end
  end

  // Occupancy bookkeeping: simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (wr_fire_s && !rd_fire_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (!wr_fire_s && rd_fire_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers and status flags, all moving on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == {CW{1'b0}});
      full_r  <= (count_nxt_s == CW'(DEPTH));
    end
  end

  // FIFO storage; cleared on reset so a flushed FIFO never exposes stale bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (wr_fire_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // Registered read port: data and a one-cycle valid pulse after each pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
    end else if (rd_fire_s) begin
      rd_data_r  <= mem_r[rd_ptr_r];
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

`ifdef HS_RX_BYTECNT_EN
  logic [15:0] rx_bytes_r;

  // Lifetime write counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_bytes_r <= 16'h0000;
    end else if (wr_fire_s) begin
      rx_bytes_r <= rx_bytes_r + 16'h0001;
    end
  end

  assign rx_bytes = rx_bytes_r;
`endif

  assign ack_o    = ack_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign count    = count_r;

endmodule

// File: tb/tb_hs_rx_fifo.sv
// tb_hs_rx_fifo: directed self-checking bench for hs_rx_fifo (DEPTH=4, ACK_HOLD=2).
module tb_hs_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       rdy_i;
  logic [7:0] data_i;
  logic       ack_o;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [2:0] count;
`ifdef HS_RX_BYTECNT_EN
  logic [15:0] rx_bytes;
`endif

  int checks;
  int errors;
  int exp_writes;

  hs_rx_fifo #(.DEPTH(4), .ACK_HOLD(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy_i    (rdy_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count)
`ifdef HS_RX_BYTECNT_EN
    ,
    .rx_bytes (rx_bytes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sender handshake: returns cycles until ack rose and cycles ack stayed high.
  task automatic send_byte(input logic [7:0] d, output int lat, output int hi);
    lat = 0;
    hi  = 0;
    rdy_i  = 1'b1;
    data_i = d;
    while (!ack_o && lat < 50) begin
      tick();
      lat++;
    end
    while (ack_o && hi < 20) begin
      hi++;
      tick();
    end
    rdy_i = 1'b0;
    tick();
  endtask

  // One-cycle pop, checking the registered read result.
  task automatic pop_check(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq({tag, "_valid"}, rd_valid, 1'b1);
    check_eq({tag, "_data"}, rd_data, exp);
    tick();
  endtask

  int lat;
  int hi;
  int ack_seen;
  int got;
  logic [7:0] exp_q [10];

  initial begin
    checks = 0;
    errors = 0;
    exp_writes = 0;
    rst_n  = 1'b0;
    rdy_i  = 1'b0;
    data_i = 8'h00;
    rd_en  = 1'b0;
    #12;
    check_eq("rst_ack", ack_o, 1'b0);
    check_eq("rst_rd_data", rd_data, 8'h00);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_count", count, 3'd0);
    check_eq("rst_empty", empty, 1'b1);
    check_eq("rst_full", full, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single transfer
    send_byte(8'hA5, lat, hi);
    exp_writes++;
    check_eq("t1_ack_lat", lat, 1);
    check_eq("t1_ack_len", hi, 2);
    check_eq("t1_count", count, 3'd1);
    check_eq("t1_empty", empty, 1'b0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("t1_rd_valid", rd_valid, 1'b1);
    check_eq("t1_rd_data", rd_data, 8'hA5);
    check_eq("t1_empty_after", empty, 1'b1);
    tick();
    check_eq("t1_valid_pulse", rd_valid, 1'b0);

    // Fill and stall
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'(i), lat, hi);
      exp_writes++;
      check_eq("t2_fill_ack_len", hi, 2);
    end
    check_eq("t2_full", full, 1'b1);
    check_eq("t2_count", count, 3'd4);
    rdy_i  = 1'b1;
    data_i = 8'h05;
    ack_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack_o) ack_seen++;
    end
    check_eq("t2_stall_no_ack", ack_seen, 0);
    check_eq("t2_stall_count", count, 3'd4);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("t2_pop_data", rd_data, 8'h01);
    check_eq("t2_pop_no_write", ack_o, 1'b0);
    check_eq("t2_pop_count", count, 3'd3);
    tick();
    exp_writes++;
    check_eq("t2_late_ack", ack_o, 1'b1);
    check_eq("t2_late_count", count, 3'd4);
    tick();
    tick();
    check_eq("t2_ack_drop", ack_o, 1'b0);
    rdy_i = 1'b0;
    tick();
    for (int i = 2; i <= 5; i++) begin
      pop_check("t2_drain", 8'(i));
    end
    check_eq("t2_empty", empty, 1'b1);

    // Held rdy_i yields exactly one capture
    rdy_i  = 1'b1;
    data_i = 8'h3C;
    for (int i = 0; i < 20; i++) tick();
    exp_writes++;
    check_eq("t3_one_write", count, 3'd1);
    rdy_i = 1'b0;
    tick();
    send_byte(8'h3D, lat, hi);
    exp_writes++;
    check_eq("t3_second_lat", lat, 1);
    check_eq("t3_count", count, 3'd2);
    pop_check("t3_first", 8'h3C);
    pop_check("t3_second", 8'h3D);

    // Wrap with concurrent reads
    for (int i = 0; i < 10; i++) exp_q[i] = 8'h10 + 8'(i);
    got = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send_byte(exp_q[i], lat, hi);
          exp_writes++;
          check_eq("t4_ack_len", hi, 2);
        end
      end
      begin
        for (int c = 0; c < 400 && got < 10; c++) begin
          if (rd_valid) begin
            check_eq("t4_order", rd_data, exp_q[got]);
            got++;
          end
          if (count > 3'd4) check_eq("t4_count_bound", count, 3'd4);
          rd_en = ~empty;
          tick();
        end
        rd_en = 1'b0;
      end
    join
    check_eq("t4_all_read", got, 10);
    tick();
    check_eq("t4_empty", empty, 1'b1);

    // Empty read is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("t5_empty_rd_valid", rd_valid, 1'b0);
    check_eq("t5_empty_rd_hold", rd_data, 8'h19);
    check_eq("t5_empty_count", count, 3'd0);

    // Reset during RX_ACK with three entries
    send_byte(8'h31, lat, hi);
    send_byte(8'h32, lat, hi);
    rdy_i  = 1'b1;
    data_i = 8'h33;
    tick();
    check_eq("t5_in_ack", ack_o, 1'b1);
    check_eq("t5_count3", count, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    exp_writes = 0;
    check_eq("t5_rst_ack", ack_o, 1'b0);
    check_eq("t5_rst_count", count, 3'd0);
    check_eq("t5_rst_empty", empty, 1'b1);
    rdy_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'h44, lat, hi);
    exp_writes++;
    check_eq("t5_post_lat", lat, 1);
    check_eq("t5_post_len", hi, 2);
    pop_check("t5_post", 8'h44);
`ifdef HS_RX_BYTECNT_EN
    check_eq("bytecnt", rx_bytes, exp_writes);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
